// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter with valid/ready load and tc pulse.
// Optional macro SYNC_DOWN_COUNTER_AUTO_RELOAD_EN enables periodic auto-reload.
module sync_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_value,
   output logic             load_ready,
   input  logic             en,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             load_acc;

`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   assign load_acc = load_valid && (state_q == S_IDLE);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (load_acc) begin
               count_d = load_value;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               count_d = '0;
               state_d = S_IDLE;
            end else if (en) begin
               // Zero check precedes decrement, so the count never wraps
               if (count_q == '0) begin
                  tc_d = 1'b1;
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
                  count_d = reload_q;
`else
                  state_d = S_IDLE;
`endif
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
   assign reload_d = load_acc ? load_value : reload_q;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         tc_q     <= 1'b0;
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         tc_q     <= tc_d;
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   assign load_ready = (state_q == S_IDLE);
   assign busy       = (state_q == S_RUN);
   assign count      = count_q;
   assign tc         = tc_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter: directed scenarios plus
// randomized traffic against a behavioural countdown model.
module tb_sync_down_counter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         load_valid;
   logic [W-1:0] load_value;
   logic         load_ready;
   logic         en;
   logic         abort;
   logic [W-1:0] count;
   logic         busy;
   logic         tc;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model: running flag, remaining count, tc pulse, period
   bit m_valid = 0;
   bit m_run;
   int m_cnt;
   bit m_tc;
   int m_rel;

   sync_down_counter #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_value (load_value),
      .load_ready (load_ready),
      .en         (en),
      .abort      (abort),
      .count      (count),
      .busy       (busy),
      .tc         (tc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!reset) begin
         m_valid = 1;
         m_run   = 0;
         m_cnt   = 0;
         m_tc    = 0;
         m_rel   = 0;
      end else if (m_valid) begin
         m_tc = 0;
         if (!m_run) begin
            if (load_valid) begin
               m_cnt = int'(load_value);
               m_rel = int'(load_value);
               m_run = 1;
            end
         end else if (abort) begin
            m_run = 0;
            m_cnt = 0;
         end else if (en) begin
            if (m_cnt > 0) begin
               m_cnt = m_cnt - 1;
            end else begin
               m_tc = 1;
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
               m_cnt = m_rel;
`else
               m_run = 0;
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_count", int'(count), m_cnt);
         chk("m_busy", int'(busy), int'(m_run));
         chk("m_ready", int'(load_ready), int'(!m_run));
         chk("m_tc", int'(tc), int'(m_tc));
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic flush();
      load_valid = 0;
      en         = 0;
      abort      = 1;
      cyc();
      abort = 0;
      chk("flush_busy", int'(busy), 0);
   endtask

   initial begin
      int exp3 [7] = '{3, 2, 2, 1, 1, 0, 0};
      reset      = 0;
      load_valid = 1;
      load_value = 4'd7;
      en         = 1;
      abort      = 0;

      // reset dominates load and enable
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("rst_count", int'(count), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_tc", int'(tc), 0);
         chk("rst_ready", int'(load_ready), 1);
      end

      // load 5, count to terminal
      reset      = 1;
      load_value = 4'd5;
      cyc();
      load_valid = 0;
      chk("l5_count", int'(count), 5);
      chk("l5_busy", int'(busy), 1);
      chk("l5_ready", int'(load_ready), 0);
      for (int i = 4; i >= 0; i--) begin
         cyc();
         chk("l5_dec", int'(count), i);
         chk("l5_notc", int'(tc), 0);
      end
      cyc();
      chk("l5_tc", int'(tc), 1);
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
      chk("l5_rl_busy", int'(busy), 1);
      chk("l5_rl_count", int'(count), 5);
`else
      chk("l5_busy0", int'(busy), 0);
      chk("l5_ready1", int'(load_ready), 1);
`endif
      flush();
      chk("idle_abort_count", int'(count), 0);

      // load 3 with en toggling
      load_valid = 1;
      load_value = 4'd3;
      cyc();
      load_valid = 0;
      for (int k = 0; k < 8; k++) begin
         en = (k % 2 == 1);
         cyc();
         if (k < 7) begin
            chk("tog_count", int'(count), exp3[k]);
            chk("tog_notc", int'(tc), 0);
         end else begin
            chk("tog_tc", int'(tc), 1);
         end
      end
      flush();

      // load 9, second load ignored, abort at 6
      load_valid = 1;
      load_value = 4'd9;
      en         = 1;
      cyc();
      chk("l9_count", int'(count), 9);
      load_value = 4'd3;
      for (int i = 8; i >= 6; i--) begin
         cyc();
         chk("l9_noreload", int'(count), i);
      end
      load_valid = 0;
      abort      = 1;
      cyc();
      abort = 0;
      en    = 0;
      chk("ab_count", int'(count), 0);
      chk("ab_busy", int'(busy), 0);
      chk("ab_tc", int'(tc), 0);
      cyc();
      chk("ab_tc2", int'(tc), 0);

      // load 0, tc immediately, back-to-back load
      load_valid = 1;
      load_value = 4'd0;
      en         = 1;
      cyc();
      chk("l0_busy", int'(busy), 1);
      chk("l0_tc0", int'(tc), 0);
      load_value = 4'd2;
      cyc();
      chk("l0_tc", int'(tc), 1);
`ifndef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
      cyc();
      chk("b2b_count", int'(count), 2);
      chk("b2b_busy", int'(busy), 1);
`endif
      flush();

      // load 2 periodic behaviour
      load_valid = 1;
      load_value = 4'd2;
      en         = 1;
      cyc();
      load_valid = 0;
      for (int i = 1; i <= 6; i++) begin
         cyc();
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
         chk("per_tc", int'(tc), int'(i == 3 || i == 6));
         chk("per_busy", int'(busy), 1);
`else
         chk("one_tc", int'(tc), int'(i == 3));
         chk("one_busy", int'(busy), int'(i < 3));
`endif
      end
      flush();

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom % 60) != 0;
         load_valid = ($urandom % 3) == 0;
         load_value = W'($urandom);
         en         = ($urandom % 4) != 0;
         abort      = ($urandom % 25) == 0;
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
